// File: rtl/adaptive_threshold_ctrl_if.sv
// adaptive_threshold_ctrl_if
//   Bundles every non-clock signal of the adaptive-threshold sequencer.
//   The signal names match the controller's port list.
//
//   Modports:
//     slave  - the controller side (adaptive_threshold_ctrl).
//     master - the host / filter / RAM side that drives the controller.
//
//   Signals:
//     iStart, iFiltFinished           start request, box-filter finished flag
//     iFiltCol/Row, iHostCol/Row      candidate image-RAM read addresses
//     iImageData, iMeanData           asynchronous RAM read data
//     oBusy, oDone, oFiltReset        sequencer status and filter reset
//     oImageCol/Row, oMeanCol/Row     RAM read addresses
//     oBinCol/Row, oBinData, oBinWren binary-RAM write port (registered)
interface adaptive_threshold_ctrl_if #(
  parameter int WIDTH_BITS  = 7,
  parameter int HEIGHT_BITS = 7
);
  logic                   iStart;
  logic                   oBusy;
  logic                   oDone;
  logic                   oFiltReset;
  logic                   iFiltFinished;
  logic [WIDTH_BITS-1:0]  iFiltCol;
  logic [HEIGHT_BITS-1:0] iFiltRow;
  logic [WIDTH_BITS-1:0]  iHostCol;
  logic [HEIGHT_BITS-1:0] iHostRow;
  logic [WIDTH_BITS-1:0]  oImageCol;
  logic [HEIGHT_BITS-1:0] oImageRow;
  logic [7:0]             iImageData;
  logic [WIDTH_BITS-1:0]  oMeanCol;
  logic [HEIGHT_BITS-1:0] oMeanRow;
  logic [7:0]             iMeanData;
  logic [WIDTH_BITS-1:0]  oBinCol;
  logic [HEIGHT_BITS-1:0] oBinRow;
  logic [7:0]             oBinData;
  logic                   oBinWren;

  modport slave (
    input  iStart, iFiltFinished, iFiltCol, iFiltRow, iHostCol, iHostRow,
           iImageData, iMeanData,
    output oBusy, oDone, oFiltReset, oImageCol, oImageRow, oMeanCol, oMeanRow,
           oBinCol, oBinRow, oBinData, oBinWren
  );

  modport master (
    output iStart, iFiltFinished, iFiltCol, iFiltRow, iHostCol, iHostRow,
           iImageData, iMeanData,
    input  oBusy, oDone, oFiltReset, oImageCol, oImageRow, oMeanCol, oMeanRow,
           oBinCol, oBinRow, oBinData, oBinWren
  );
endinterface

// File: rtl/adaptive_threshold_ctrl.sv
// adaptive_threshold_ctrl
//   Top-level sequencer for the adaptive-thresholding pipeline.
//   On iStart it runs the box-filter pass, then scans the image one pixel per
//   cycle. It compares each pixel against its local mean minus OFFSET_C and
//   writes a binary (0/255) image. It also owns the image-RAM read-address mux
//   that selects between the filter, the threshold scanner and the host.
//
//   Ports:
//     clock  - system clock, rising edge
//     reset  - asynchronous active-low reset
//     bus    - adaptive_threshold_ctrl_if.slave. It carries start/busy/done,
//              the filter handshake, the image/mean RAM read ports and the
//              binary-RAM write port.
//
//   Optional feature:
//     THRESH_INVERT_EN - when defined, the output polarity is inverted:
//                        white pixels become 0 and dark pixels become 255.
module adaptive_threshold_ctrl #(
  parameter int              WIDTH_BITS  = 7,
  parameter int              HEIGHT_BITS = 7,
  parameter int              WIDTH       = 2**WIDTH_BITS,
  parameter int              HEIGHT      = 2**HEIGHT_BITS,
  parameter logic signed [8:0] OFFSET_C  = 9'sd5
) (
  input logic                       clock,
  input logic                       reset,
  adaptive_threshold_ctrl_if.slave  bus
);

  localparam int POS_BITS = WIDTH_BITS + HEIGHT_BITS;
  localparam logic [POS_BITS-1:0] LAST_POS = POS_BITS'(WIDTH * HEIGHT - 1);

  typedef enum logic [2:0] {
    IDLE,
    FILT_RST,
    FILT_RUN,
    THRESH,
    DONE
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [POS_BITS-1:0] pos;
  logic                done_q;
  logic                white;
  logic signed [9:0]   pix_s;
  logic signed [9:0]   mean_adj;
  logic [7:0]          bin_value;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:     if (bus.iStart) state_next = FILT_RST;
      FILT_RST: state_next = FILT_RUN;
      FILT_RUN: if (bus.iFiltFinished) state_next = THRESH;
      THRESH:   if (pos == LAST_POS) state_next = DONE;
      DONE:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // The image-address mux is combinational on the current state, so the RAM
  // address follows the owner in the same cycle that the state changes.
  always_comb begin
    bus.oBusy      = (state != IDLE);
    bus.oFiltReset = (state != FILT_RUN);
    bus.oImageCol  = bus.iHostCol;
    bus.oImageRow  = bus.iHostRow;
    unique case (state)
      FILT_RUN: begin
        bus.oImageCol = bus.iFiltCol;
        bus.oImageRow = bus.iFiltRow;
      end
      THRESH: begin
        bus.oImageCol = pos[WIDTH_BITS-1:0];
        bus.oImageRow = pos[POS_BITS-1:WIDTH_BITS];
      end
      default: begin
        bus.oImageCol = bus.iHostCol;
        bus.oImageRow = bus.iHostRow;
      end
    endcase
  end

  assign bus.oMeanCol = pos[WIDTH_BITS-1:0];
  assign bus.oMeanRow = pos[POS_BITS-1:WIDTH_BITS];
  assign bus.oDone    = done_q;

  // The comparison is done in 10-bit signed arithmetic so that a mean below
  // OFFSET_C goes negative instead of wrapping around.
  assign pix_s    = signed'({2'b00, bus.iImageData});
  assign mean_adj = signed'({2'b00, bus.iMeanData}) - {OFFSET_C[8], OFFSET_C};
  assign white    = (pix_s > mean_adj);

`ifdef THRESH_INVERT_EN
  assign bin_value = white ? 8'd0 : 8'd255;
`else
  assign bin_value = white ? 8'd255 : 8'd0;
`endif

  // pos only advances in THRESH. It wraps back to zero on the last pixel,
  // so every run starts its scan from the origin.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pos <= '0;
    end else if (state == THRESH) begin
      pos <= pos + 1'b1;
    end
  end

  // oDone is high only in the IDLE cycle that directly follows DONE.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      done_q <= 1'b0;
    end else begin
      done_q <= (state == DONE);
    end
  end

  // The write port lags the scan by one cycle. The write for the last pixel
  // therefore lands during DONE.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bus.oBinWren <= 1'b0;
      bus.oBinCol  <= '0;
      bus.oBinRow  <= '0;
      bus.oBinData <= 8'd0;
    end else begin
      bus.oBinWren <= (state == THRESH);
      bus.oBinCol  <= pos[WIDTH_BITS-1:0];
      bus.oBinRow  <= pos[POS_BITS-1:WIDTH_BITS];
      bus.oBinData <= bin_value;
    end
  end

endmodule

// File: tb/tb_adaptive_threshold_ctrl.sv
// tb_adaptive_threshold_ctrl
//   Bench for adaptive_threshold_ctrl on a 4x4 image. It includes an image RAM
//   model, a mean RAM model, a box-filter model that finishes 160 cycles after
//   its reset is released, and a write scoreboard.
module tb_adaptive_threshold_ctrl;

  localparam int WB   = 2;
  localparam int HB   = 2;
  localparam int NPIX = 16;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic fin_pulse = 1'b0;
  int   fcnt = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   done_cnt = 0;
  int   d0;

  logic [7:0] img_mem  [NPIX];
  logic [7:0] mean_mem [NPIX];

  typedef struct {
    logic [1:0] col;
    logic [1:0] row;
    logic [7:0] data;
  } wr_t;

  wr_t exp_q[$];

  adaptive_threshold_ctrl_if #(.WIDTH_BITS(WB), .HEIGHT_BITS(HB)) bus_if ();

  adaptive_threshold_ctrl #(
    .WIDTH_BITS (WB),
    .HEIGHT_BITS(HB),
    .OFFSET_C   (9'sd5)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus_if)
  );

  always #5 clock = ~clock;

  // Asynchronous-read RAM models.
  assign bus_if.iImageData = img_mem[{bus_if.oImageRow, bus_if.oImageCol}];
  assign bus_if.iMeanData  = mean_mem[{bus_if.oMeanRow, bus_if.oMeanCol}];

  // Box-filter model: it sweeps addresses and reports that it has finished
  // 160 cycles after its reset is released.
  always @(posedge clock) begin
    if (bus_if.oFiltReset) fcnt <= 0;
    else                   fcnt <= fcnt + 1;
  end
  assign bus_if.iFiltCol      = fcnt[1:0];
  assign bus_if.iFiltRow      = fcnt[3:2];
  assign bus_if.iFiltFinished = (!bus_if.oFiltReset && fcnt >= 160) || fin_pulse;

  function automatic logic [7:0] expPixel(int idx);
    logic w;
    w = int'(img_mem[idx]) > (int'(mean_mem[idx]) - 5);
`ifdef THRESH_INVERT_EN
    return w ? 8'd0 : 8'd255;
`else
    return w ? 8'd255 : 8'd0;
`endif
  endfunction

  task automatic pushRun();
    wr_t e;
    for (int i = 0; i < NPIX; i++) begin
      e.col  = 2'(i % 4);
      e.row  = 2'(i / 4);
      e.data = expPixel(i);
      exp_q.push_back(e);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] expv);
    vectors++;
    assert (obs === expv)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Pulses iStart for one cycle and picks a new host address.
  task automatic applyStimulus();
    @(posedge clock); #1;
    bus_if.iStart   = 1'b1;
    bus_if.iHostCol = 2'($urandom_range(0, 3));
    bus_if.iHostRow = 2'($urandom_range(0, 3));
    @(posedge clock); #1;
    bus_if.iStart = 1'b0;
  endtask

  task automatic waitDone(input string tag);
    for (int c = 0; c < 2000; c++) begin
      @(negedge clock);
      if (bus_if.oDone) break;
    end
    checkOutput(tag, 32'(bus_if.oDone), 32'd1);
  endtask

  task automatic idleCycles(input int n);
    for (int c = 0; c < n; c++) @(negedge clock);
  endtask

  // Write scoreboard and address-mux monitor.
  always @(negedge clock) begin
    if (reset) begin
      if (bus_if.oDone) done_cnt++;
      if (bus_if.oBinWren) begin
        vectors++;
        assert (exp_q.size() != 0)
        else begin
          miscompares++;
          $error("[TB] FAIL unexpected_write observed=col%0d,row%0d expected=no write",
                 bus_if.oBinCol, bus_if.oBinRow);
        end
        if (exp_q.size() != 0) begin
          wr_t e;
          e = exp_q.pop_front();
          vectors++;
          assert ({bus_if.oBinRow, bus_if.oBinCol, bus_if.oBinData} === {e.row, e.col, e.data})
          else begin
            miscompares++;
            $error("[TB] FAIL bin_write observed=r%0d c%0d d%0d expected=r%0d c%0d d%0d",
                   bus_if.oBinRow, bus_if.oBinCol, bus_if.oBinData, e.row, e.col, e.data);
          end
        end
      end
      if (!bus_if.oBusy) begin
        vectors++;
        assert ({bus_if.oImageRow, bus_if.oImageCol} === {bus_if.iHostRow, bus_if.iHostCol})
        else begin
          miscompares++;
          $error("[TB] FAIL mux_host observed=%0d expected=%0d",
                 {bus_if.oImageRow, bus_if.oImageCol}, {bus_if.iHostRow, bus_if.iHostCol});
        end
      end else if (!bus_if.oFiltReset) begin
        vectors++;
        assert ({bus_if.oImageRow, bus_if.oImageCol} === {bus_if.iFiltRow, bus_if.iFiltCol})
        else begin
          miscompares++;
          $error("[TB] FAIL mux_filt observed=%0d expected=%0d",
                 {bus_if.oImageRow, bus_if.oImageCol}, {bus_if.iFiltRow, bus_if.iFiltCol});
        end
      end
    end
  end

  initial begin
    bus_if.iStart   = 1'b0;
    bus_if.iHostCol = 2'd3;
    bus_if.iHostRow = 2'd1;
    for (int i = 0; i < NPIX; i++) begin
      img_mem[i]  = 8'd100;
      mean_mem[i] = 8'd100;
    end

    // Reset state
    idleCycles(3);
    checkOutput("rst_busy",     32'(bus_if.oBusy),      32'd0);
    checkOutput("rst_done",     32'(bus_if.oDone),      32'd0);
    checkOutput("rst_filtrst",  32'(bus_if.oFiltReset), 32'd1);
    checkOutput("rst_wren",     32'(bus_if.oBinWren),   32'd0);
    checkOutput("rst_bin_addr", 32'({bus_if.oBinRow, bus_if.oBinCol}), 32'd0);
    checkOutput("rst_bin_data", 32'(bus_if.oBinData),   32'd0);
    @(posedge clock); #1;
    reset = 1'b1;
    idleCycles(2);

    // Scenario 1: uniform image, all pixels white
    d0 = done_cnt;
    pushRun();
    applyStimulus();
    checkOutput("s1_busy", 32'(bus_if.oBusy), 32'd1);
    waitDone("s1_done_seen");
    idleCycles(5);
    checkOutput("s1_done_count", 32'(done_cnt - d0), 32'd1);
    checkOutput("s1_queue_empty", 32'(exp_q.size()), 32'd0);
    checkOutput("s1_busy_after", 32'(bus_if.oBusy), 32'd0);

    // Scenario 2: one dark pixel at col 1, row 2; two runs back to back
    img_mem[9] = 8'd90;
    d0 = done_cnt;
    pushRun();
    pushRun();
    applyStimulus();
    waitDone("s2_done_first");
    bus_if.iStart = 1'b1;
    @(posedge clock); #1;
    bus_if.iStart = 1'b0;
    checkOutput("s2_b2b_busy", 32'(bus_if.oBusy), 32'd1);
    waitDone("s2_done_second");
    idleCycles(5);
    checkOutput("s2_done_count", 32'(done_cnt - d0), 32'd2);
    checkOutput("s2_queue_empty", 32'(exp_q.size()), 32'd0);

    // Scenario 3: iStart mid-THRESH and iFiltFinished in IDLE are both ignored
    d0 = done_cnt;
    pushRun();
    applyStimulus();
    for (int c = 0; c < 1000; c++) begin
      @(negedge clock);
      if (bus_if.oBinWren) break;
    end
    checkOutput("s3_in_thresh", 32'(bus_if.oBinWren), 32'd1);
    bus_if.iStart = 1'b1;
    @(posedge clock); #1;
    bus_if.iStart = 1'b0;
    waitDone("s3_done_seen");
    idleCycles(5);
    checkOutput("s3_done_count", 32'(done_cnt - d0), 32'd1);
    checkOutput("s3_queue_empty", 32'(exp_q.size()), 32'd0);
    checkOutput("s3_busy_after", 32'(bus_if.oBusy), 32'd0);
    @(posedge clock); #1;
    fin_pulse = 1'b1;
    @(posedge clock); #1;
    fin_pulse = 1'b0;
    idleCycles(3);
    checkOutput("s3_fin_idle_busy", 32'(bus_if.oBusy), 32'd0);
    checkOutput("s3_fin_idle_filtrst", 32'(bus_if.oFiltReset), 32'd1);

    // Scenario 4: asynchronous reset at pos 7 of THRESH, then a fresh run
    pushRun();
    applyStimulus();
    for (int c = 0; c < 1000; c++) begin
      @(negedge clock);
      if (bus_if.oBinWren && bus_if.oBinRow == 2'd1 && bus_if.oBinCol == 2'd2) break;
    end
    checkOutput("s4_at_pos7", 32'({bus_if.oBinWren, bus_if.oBinRow, bus_if.oBinCol}),
                32'b1_01_10);
    #1 reset = 1'b0;
    #1;
    checkOutput("s4_async_wren", 32'(bus_if.oBinWren), 32'd0);
    checkOutput("s4_async_filtrst", 32'(bus_if.oFiltReset), 32'd1);
    checkOutput("s4_async_busy", 32'(bus_if.oBusy), 32'd0);
    exp_q.delete();
    @(posedge clock); #1;
    reset = 1'b1;
    d0 = done_cnt;
    pushRun();
    applyStimulus();
    waitDone("s4_done_seen");
    idleCycles(5);
    checkOutput("s4_done_count", 32'(done_cnt - d0), 32'd1);
    checkOutput("s4_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
